// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice processes one bit per clock, LSB first.
// A start/busy/done handshake frames each WIDTH-bit operation.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] sum_msb;
   logic             carry;
   logic             carry_next;
   logic             sum_bit;
   logic             last_bit;
   logic [CW-1:0]    cnt;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sum_bit             = a_sr[0] ^ b_sr[0] ^ carry;
      carry_next          = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
      sum_msb             = '0;
      sum_msb[WIDTH-1]    = sum_bit;
      res_next            = (res_sr >> 1) | sum_msb;
   end

   // The last slice writes S/Cout/V directly so they become visible together with done;
   // the carry entering that slice is the MSB carry-in used for overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         S      <= '0;
         Cout   <= 1'b0;
         V      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B ^ {WIDTH{Sub}};
                  carry <= Cin ^ Sub;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               carry  <= carry_next;
               if (last_bit) begin
                  S    <= res_next;
                  Cout <= carry_next;
                  V    <= carry ^ carry_next;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
